arbiter_puf_engine: RTL and testbench

Parametrised successor to the single-chain arbiter PUF: K parallel N-stage arbiter chains whose outputs are XOR-combined, re-evaluated VOTES times per challenge with majority voting, and sequenced by an FSM that expands one seed challenge into RESP_W response bits via an LFSR. It sits between the PUF delay fabric and the key/authentication logic and presents a start/done handshake. A test mode replaces the physical arbiter outputs with a deterministic input so the control path is verifiable in simulation.

---
 rtl/arbiter_puf_engine.sv | 150 +++++++++++++++
 tb/tb_arbiter_puf_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_puf_engine.sv
// K-chain XOR arbiter PUF with majority voting.
// One seed challenge is expanded via LFSR into RESP_W response bits.
module arbiter_puf_engine #(
  parameter int N      = 64,
  parameter int K      = 4,
  parameter int VOTES  = 5,
  parameter int SETTLE = 8,
  parameter int RESP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N-1:0]      challenge,
  input  logic              test_mode,
  input  logic [K-1:0]      tm_bits,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] unstable,
  output logic [N-1:0]      chal_o
);

  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = $clog2(RESP_W + 1);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [VW-1:0] VMAX  = VW'(VOTES);
  localparam logic [VW-1:0] VLAST = VW'(VOTES - 1);
  localparam logic [VW-1:0] HALF  = VW'(VOTES / 2);
  localparam logic [BW-1:0] BLAST = BW'(RESP_W - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_LAUNCH,
    S_SETTLE, S_SAMPLE, S_DECIDE, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]  chal;
  logic [VW-1:0] ones, votes;
  logic [BW-1:0] bits;
  logic [SW-1:0] scnt;
  logic [K-1:0]  rail_a, arb, res;
  logic          launch, e, b;

  assign launch = (state == S_LAUNCH) || (state == S_SETTLE)
               || (state == S_SAMPLE);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign chal_o = chal;

  // Mux stage pairs: a set select bit crosses the two rails.
  always_comb begin
    rail_a = '0;
    for (int k = 0; k < K; k++) begin : chain
      logic ra, rb, rt;
      ra = launch;
      rb = 1'b0;
      for (int i = 0; i < N; i++) begin
        rt = ra;
        if (chal[(i + k) % N]) begin
          ra = rb;
          rb = rt;
        end
      end
      rail_a[k] = ra;
    end
  end

  // Arbiter latches are cleared in ARM as well as by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      arb <= '0;
    else if (state == S_ARM)
      arb <= '0;
    else if (launch)
      arb <= rail_a;
  end

  assign res = test_mode ? tm_bits : arb;
  assign e   = ^res;
  assign b   = (ones > HALF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_ARM;
      S_ARM:    state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_SETTLE;
      S_SETTLE: if (scnt == SLAST) state_nx = S_SAMPLE;
      S_SAMPLE: state_nx = (votes < VLAST) ? S_ARM : S_DECIDE;
      S_DECIDE: state_nx = (bits < BLAST) ? S_ARM : S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chal     <= '0;
      resp     <= '0;
      unstable <= '0;
      ones     <= '0;
      votes    <= '0;
      bits     <= '0;
      scnt     <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          chal     <= challenge;
          resp     <= '0;
          unstable <= '0;
          ones     <= '0;
          votes    <= '0;
          bits     <= '0;
          scnt     <= '0;
        end
        S_SETTLE: begin
          scnt <= (scnt == SLAST) ? '0 : scnt + 1'b1;
        end
        S_SAMPLE: begin
          ones  <= ones + VW'(e);
          votes <= votes + 1'b1;
        end
        S_DECIDE: begin
          resp     <= {resp[RESP_W-2:0], b};
          unstable <= {unstable[RESP_W-2:0],
                       (ones != '0) && (ones != VMAX)};
          ones     <= '0;
          votes    <= '0;
          if (bits < BLAST) begin
            bits <= bits + 1'b1;
            chal <= {chal[N-2:0], chal[N-1] ^ chal[N-2] ^ chal[0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// Scoreboard bench for arbiter_puf_engine in test mode.
// Expected words come from a vote-counting model of each request.
module tb_arbiter_puf_engine;

  localparam int N    = 64;
  localparam int K    = 4;
  localparam int V    = 5;
  localparam int S    = 8;
  localparam int RW   = 8;
  localparam int EVAL = S + 3;
  localparam int BIT  = V * EVAL + 1;
  localparam int LAT  = 2 + RW * BIT;

  logic          clk, reset_n, start, test_mode, busy, done;
  logic [N-1:0]  challenge, chal_o;
  logic [K-1:0]  tm_bits;
  logic [RW-1:0] resp, unstable;

  arbiter_puf_engine #(
    .N(N), .K(K), .VOTES(V), .SETTLE(S), .RESP_W(RW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .challenge(challenge), .test_mode(test_mode),
    .tm_bits(tm_bits), .busy(busy), .done(done),
    .resp(resp), .unstable(unstable), .chal_o(chal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [RW-1:0] r;
    logic [RW-1:0] u;
    logic [N-1:0]  c;
    int            t0;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  logic [K-1:0] seq [RW*V];
  logic [N-1:0] chs [RW];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] lfsr(input logic [N-1:0] c);
    return {c[N-2:0], c[N-1] ^ c[N-2] ^ c[0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected entry per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        e = q.pop_front();
        chk("resp", 64'(resp), 64'(e.r));
        chk("unstable", 64'(unstable), 64'(e.u));
        chk("chal_final", chal_o, e.c);
        chk("latency", 64'(cyc - e.t0), 64'(LAT));
      end
    end
  end

  task automatic run_req(input logic [N-1:0] ch, input bit repulse,
                         input int abort_at);
    exp_t e;
    logic [N-1:0] c;
    int ones, w, bi, r;
    bit ok;
    w = 0;
    while (busy && w < 20) begin
      tick();
      w++;
    end
    chk("idle_before_start", 64'(busy), 64'd0);
    c = ch;
    e.r = '0;
    e.u = '0;
    for (int bb = 0; bb < RW; bb++) begin
      ones = 0;
      for (int v = 0; v < V; v++) ones += int'(^seq[bb*V+v]);
      e.r = (e.r << 1) | RW'(ones * 2 > V);
      e.u = (e.u << 1) | RW'(ones != 0 && ones != V);
      chs[bb] = c;
      if (bb < RW - 1) c = lfsr(c);
    end
    e.c  = c;
    e.t0 = cyc;
    q.push_back(e);
    challenge = ch;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b1;
    for (int n = 1; n <= LAT - 1; n++) begin
      tick();
      if (!busy) ok = 1'b0;
      bi = (n - 1) / BIT;
      r  = (n - 1) % BIT;
      if (bi < RW && r < V * EVAL && r % EVAL == 0)
        tm_bits = seq[bi*V + r/EVAL];
      if (n == 1) chk("chal_load", chal_o, ch);
      for (int bb = 0; bb < RW - 1; bb++)
        if (n == BIT * (bb + 1) + 1)
          chk("chal_step", chal_o, chs[bb+1]);
      challenge = {$urandom, $urandom};
      start = repulse && (n == 10 || n == 200);
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("abort_outs", {busy, done, resp, unstable, chal_o[31:0]}, 64'd0);
        q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        return;
      end
    end
    start = 1'b0;
    chk("busy_cont", 64'(ok), 64'd1);
    tick();
    chk("busy_fall", 64'(busy), 64'd0);
    chk("sb_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic fill_const(input logic [K-1:0] t);
    for (int i = 0; i < RW * V; i++) seq[i] = t;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    challenge = '0;
    test_mode = 1'b1;
    tm_bits   = '0;
    tick();
    chk("reset_outs", {busy, done, resp, unstable}, 64'd0);
    chk("reset_chal", chal_o, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    fill_const(4'b0001);
    run_req(64'h1, 1'b0, 0);
    chk("tp_ff_resp", 64'(resp), 64'hFF);
    chk("tp_ff_unst", 64'(unstable), 64'h00);

    fill_const(4'b0011);
    run_req({$urandom, $urandom}, 1'b0, 0);
    chk("tp_00_resp", 64'(resp), 64'h00);

    for (int i = 0; i < RW * V; i++)
      seq[i] = ((i % V) < 3) ? 4'b0001 : 4'b0000;
    run_req({$urandom, $urandom}, 1'b0, 0);
    chk("tp_mix_resp", 64'(resp), 64'hFF);
    chk("tp_mix_unst", 64'(unstable), 64'hFF);

    fill_const(4'b0111);
    run_req(64'h8000_0000_0000_0001, 1'b0, 0);

    fill_const(4'b0010);
    run_req({$urandom, $urandom}, 1'b1, 0);

    run_req({$urandom, $urandom}, 1'b0, 300);
    tick();
    chk("abort_no_done", 64'(done), 64'd0);
    run_req(64'h1234_5678_9abc_def0, 1'b0, 0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < RW * V; i++)
        seq[i] = K'($urandom_range(0, 15));
      run_req({$urandom, $urandom}, 1'b0, 0);
    end

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
